helios_host_sequencer: RTL and testbench

//  Synthesisable host-side sequencer for the Helios byte-stream protocol. Frames syndrome shots
//  (measurement rounds) into the 8-bit decoder input stream, honours backpressure, and parses the

---
 rtl/helios_host_sequencer_pkg.sv | 25 ++
 rtl/measurement_byte_serializer.sv | 81 ++++++++
 rtl/helios_host_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_helios_host_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/helios_host_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : helios_host_sequencer_pkg
//  Description : Shared message codes and sequencer state type for the
//                Helios host-side byte-stream sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package helios_host_sequencer_pkg;

    localparam logic [7:0] START_DECODING_MSG      = 8'h01;
    localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SEND_START  = 3'd1,
        WAIT_MEAS   = 3'd2,
        SEND_HEADER = 3'd3,
        SEND_DATA   = 3'd4,
        RECV        = 3'd5,
        REPORT      = 3'd6,
        DONE        = 3'd7
    } host_state_t;

endpackage
`default_nettype wire

// File: rtl/measurement_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : measurement_byte_serializer
//  Description : Shot buffer plus registered tx byte stage. Emits the start
//                code, frame header or next syndrome byte (LSB byte first).
//  Revision    : 1.0 - initial release
// ============================================================================
module measurement_byte_serializer
    import helios_host_sequencer_pkg::*;
#(
    parameter int MEAS_W = 24,
    parameter int NBYTES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [MEAS_W-1:0] meas_data,
    input  logic              load_start,
    input  logic              load_header,
    input  logic              load_data,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              tx_fire,
    output logic              last
);

    localparam int IDX_W = $clog2(NBYTES + 1);

    logic [MEAS_W-1:0] r_buf;
    logic [IDX_W-1:0]  r_byte_idx;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_is_data;

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign tx_fire  = r_tx_valid & tx_ready;
    assign last     = r_is_data && (r_byte_idx == IDX_W'(NBYTES - 1));

    // The buffer shifts down one byte per accepted data byte, so the next
    // byte to send always sits in the low eight bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf      <= '0;
            r_byte_idx <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_is_data  <= 1'b0;
        end else begin
            if (capture) begin
                r_buf <= meas_data;
            end
            if (tx_fire) begin
                r_tx_valid <= 1'b0;
                if (r_is_data) begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                    r_buf      <= r_buf >> 8;
                end else begin
                    r_byte_idx <= '0;
                end
            end else if (!r_tx_valid) begin
                if (load_start) begin
                    r_tx_data  <= START_DECODING_MSG;
                    r_tx_valid <= 1'b1;
                    r_is_data  <= 1'b0;
                end else if (load_header) begin
                    r_tx_data  <= MEASUREMENT_DATA_HEADER;
                    r_tx_valid <= 1'b1;
                    r_is_data  <= 1'b0;
                end else if (load_data) begin
                    r_tx_data  <= r_buf[7:0];
                    r_tx_valid <= 1'b1;
                    r_is_data  <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/helios_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : helios_host_sequencer
//  Description : Frames syndrome shots into the Helios decoder byte stream and
//                parses the decoder replies, for N back-to-back shots per run.
//  Revision    : 1.0 - initial release
// ============================================================================
module helios_host_sequencer
    import helios_host_sequencer_pkg::*;
#(
    parameter int GRID_WIDTH_X   = 4,
    parameter int GRID_WIDTH_Z   = 1,
    parameter int GRID_WIDTH_U   = 3,
    parameter int RESP_BYTES     = 3,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int BPR    = (GRID_WIDTH_X * GRID_WIDTH_Z + 7) >> 3,
    localparam int MEAS_W = BPR * 8 * GRID_WIDTH_U,
    localparam int NBYTES = BPR * GRID_WIDTH_U
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       num_shots,
    input  logic [MEAS_W-1:0] meas_data,
    input  logic              meas_valid,
    output logic              meas_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        res_iterations,
    output logic [15:0]       res_cycles,
    output logic              res_valid,
    output logic [15:0]       shots_done,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
);

    localparam int RX_W  = $clog2(RESP_BYTES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    generate
        if (RESP_BYTES < 3) begin : g_resp_bytes_check
            $error("helios_host_sequencer: RESP_BYTES must be at least 3");
        end
    endgenerate

    host_state_t      r_state, w_state_nxt;
    logic [15:0]      r_num_shots, r_shots_done;
    logic [RX_W-1:0]  r_rx_idx;
    logic [TMR_W-1:0] r_timer;
    logic [7:0]       r_stage_iter, r_res_iter, w_iter_nxt;
    logic [15:0]      r_stage_cyc, r_res_cyc, w_cyc_nxt;
    logic             r_err_timeout;
    logic             w_rx_last, w_timer_exp;
    logic             w_capture, w_load_start, w_load_header, w_load_data;
    logic             w_tx_fire, w_tx_last;

    measurement_byte_serializer #(
        .MEAS_W (MEAS_W),
        .NBYTES (NBYTES)
    ) u_serializer (
        .clk         (clk),
        .reset       (reset),
        .capture     (w_capture),
        .meas_data   (meas_data),
        .load_start  (w_load_start),
        .load_header (w_load_header),
        .load_data   (w_load_data),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_fire     (w_tx_fire),
        .last        (w_tx_last)
    );

    assign w_rx_last   = (r_rx_idx == RX_W'(RESP_BYTES - 1));
    assign w_timer_exp = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

    // Fold the byte being accepted into the staged reply so the final byte
    // can be published in the same cycle it arrives.
    always_comb begin
        w_iter_nxt = r_stage_iter;
        w_cyc_nxt  = r_stage_cyc;
        if (r_rx_idx == RX_W'(0)) w_iter_nxt      = rx_data;
        if (r_rx_idx == RX_W'(1)) w_cyc_nxt[15:8] = rx_data;
        if (r_rx_idx == RX_W'(2)) w_cyc_nxt[7:0]  = rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_load_start  = 1'b0;
        w_load_header = 1'b0;
        w_load_data   = 1'b0;
        meas_ready    = 1'b0;
        rx_ready      = 1'b0;
        res_valid     = 1'b0;
        done          = 1'b0;
        busy          = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (num_shots != 16'd0) ? SEND_START : DONE;
                end
            end
            SEND_START: begin
                w_load_start = 1'b1;
                if (w_tx_fire) w_state_nxt = WAIT_MEAS;
            end
            WAIT_MEAS: begin
                meas_ready = 1'b1;
                if (meas_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SEND_HEADER;
                end
            end
            SEND_HEADER: begin
                w_load_header = 1'b1;
                if (w_tx_fire) w_state_nxt = SEND_DATA;
            end
            SEND_DATA: begin
                w_load_data = 1'b1;
                if (w_tx_fire && w_tx_last) w_state_nxt = RECV;
            end
            RECV: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (w_rx_last) w_state_nxt = REPORT;
                end else if (w_timer_exp) begin
                    w_state_nxt = DONE;
                end
            end
            REPORT: begin
                res_valid   = 1'b1;
                w_state_nxt = (r_shots_done + 16'd1 == r_num_shots) ? DONE : WAIT_MEAS;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_shots   <= '0;
            r_shots_done  <= '0;
            r_rx_idx      <= '0;
            r_timer       <= '0;
            r_stage_iter  <= '0;
            r_stage_cyc   <= '0;
            r_res_iter    <= '0;
            r_res_cyc     <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && num_shots != 16'd0) begin
                        r_num_shots   <= num_shots;
                        r_shots_done  <= '0;
                        r_err_timeout <= 1'b0;
                    end
                end
                SEND_DATA: begin
                    if (w_tx_fire && w_tx_last) begin
                        r_rx_idx <= '0;
                        r_timer  <= '0;
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        r_timer      <= '0;
                        r_rx_idx     <= r_rx_idx + 1'b1;
                        r_stage_iter <= w_iter_nxt;
                        r_stage_cyc  <= w_cyc_nxt;
                        if (w_rx_last) begin
                            r_res_iter <= w_iter_nxt;
                            r_res_cyc  <= w_cyc_nxt;
                        end
                    end else if (w_timer_exp) begin
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                REPORT: r_shots_done <= r_shots_done + 16'd1;
                default: ;
            endcase
        end
    end

    assign res_iterations = r_res_iter;
    assign res_cycles     = r_res_cyc;
    assign shots_done     = r_shots_done;
    assign err_timeout    = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_helios_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_helios_host_sequencer
//  Description : Scoreboard bench for helios_host_sequencer with a simple
//                syndrome source and decoder reply FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_helios_host_sequencer;
    import helios_host_sequencer_pkg::*;

    localparam int GX  = 4;
    localparam int GZ  = 1;
    localparam int GU  = 3;
    localparam int TMO = 16;
    localparam int BPR = (GX * GZ + 7) >> 3;
    localparam int NB  = BPR * GU;
    localparam int MW  = NB * 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   num_shots = '0;
    logic [MW-1:0] meas_data = '0;
    logic          meas_valid = 1'b0;
    logic          meas_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    res_iterations;
    logic [15:0]   res_cycles;
    logic          res_valid;
    logic [15:0]   shots_done;
    logic          busy;
    logic          done;
    logic          err_timeout;

    helios_host_sequencer #(
        .GRID_WIDTH_X   (GX),
        .GRID_WIDTH_Z   (GZ),
        .GRID_WIDTH_U   (GU),
        .RESP_BYTES     (3),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_shots      (num_shots),
        .meas_data      (meas_data),
        .meas_valid     (meas_valid),
        .meas_ready     (meas_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .res_iterations (res_iterations),
        .res_cycles     (res_cycles),
        .res_valid      (res_valid),
        .shots_done     (shots_done),
        .busy           (busy),
        .done           (done),
        .err_timeout    (err_timeout)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tx_seen = 0, dones = 0, last_tx_cyc = 0, err_rise_cyc = 0;
    int tx_mode = 0;
    int hold_base = 0;
    bit hold3 = 1'b0, rand_gaps = 1'b0;
    bit meas_fire_seen = 1'b0, rx_fire_seen = 1'b0, prev_stall = 1'b0, err_prev = 1'b0;
    logic [7:0] prev_data = '0;

    logic [7:0]    exp_tx[$];
    logic [23:0]   exp_res[$];
    logic [MW-1:0] meas_q[$];
    logic [7:0]    rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: observes handshakes and scores DUT outputs on the falling edge.
    initial forever begin
        @(negedge clk);
        cyc++;
        meas_fire_seen = meas_valid && meas_ready;
        rx_fire_seen   = rx_valid && rx_ready;
        if (prev_stall && !reset) check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
        prev_stall = tx_valid && !tx_ready && !reset;
        prev_data  = tx_data;
        if (tx_valid && tx_ready) begin
            tx_seen++;
            last_tx_cyc = cyc;
            if (exp_tx.size() == 0) begin
                total++; bad++;
                $display("FAIL tx_extra: got %0h expected no byte", tx_data);
            end else begin
                check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
        end
        if (res_valid) begin
            if (exp_res.size() == 0) begin
                total++; bad++;
                $display("FAIL res_extra: got %0h expected no result", {res_iterations, res_cycles});
            end else begin
                check("res", 32'({res_iterations, res_cycles}), 32'(exp_res.pop_front()));
            end
        end
        if (done) dones++;
        if (err_timeout && !err_prev) err_rise_cyc = cyc;
        err_prev = err_timeout;
    end

    // Source / sink driver: syndrome source, decoder reply FIFO, tx backpressure.
    initial forever begin
        @(posedge clk);
        #1;
        if (meas_fire_seen && meas_q.size() > 0) meas_q.delete(0);
        if (rx_fire_seen && rx_q.size() > 0) rx_q.delete(0);
        meas_valid = (meas_q.size() > 0) && (!rand_gaps || $urandom_range(3) != 0);
        meas_data  = (meas_q.size() > 0) ? meas_q[0] : '0;
        rx_valid   = (rx_q.size() > 0) && (!rand_gaps || $urandom_range(3) != 0);
        rx_data    = (rx_q.size() > 0) ? rx_q[0] : '0;
        if (hold3)             tx_ready = (tx_seen - hold_base) < 3;
        else if (tx_mode == 1) tx_ready = ~tx_ready;
        else if (tx_mode == 2) tx_ready = ($urandom_range(1) == 1);
        else                   tx_ready = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_shot(input logic [MW-1:0] m, input logic [7:0] it,
                             input logic [15:0] cy, input bit reply);
        logic [MW-1:0] t;
        meas_q.push_back(m);
        exp_tx.push_back(MEASUREMENT_DATA_HEADER);
        for (int b = 0; b < NB; b++) begin
            t = m >> (8 * b);
            exp_tx.push_back(t[7:0]);
        end
        if (reply) begin
            rx_q.push_back(it);
            rx_q.push_back(cy[15:8]);
            rx_q.push_back(cy[7:0]);
            exp_res.push_back({it, cy});
        end
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1'b1; num_shots = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (dones == d0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (dones == d0) begin
            total++; bad++;
            $display("FAIL run_wait: got no done expected done within %0d cycles", k);
        end
    endtask

    task automatic run(input int n, input bit fixed, input bit reply,
                       input int txm, input bit rnd, input bit poke);
        int d0;
        logic [MW-1:0] m;
        logic [7:0] it;
        logic [15:0] cy;
        d0 = dones; tx_mode = txm; rand_gaps = rnd;
        if (n > 0) exp_tx.push_back(START_DECODING_MSG);
        for (int i = 0; i < n; i++) begin
            if (fixed) begin
                m = MW'(1); it = 8'h02; cy = 16'h001A;
            end else begin
                m = '0;
                for (int k = 0; k < GU; k++)
                    for (int j = 0; j < GX * GZ; j++)
                        m[k * BPR * 8 + j] = 1'($urandom_range(1));
                it = 8'($urandom_range(255));
                cy = 16'($urandom_range(65535));
            end
            push_shot(m, it, cy, reply);
        end
        pulse_start(n);
        if (poke) begin
            repeat (6) @(posedge clk);
            #1 start = 1'b1; num_shots = 16'd7;
            @(posedge clk);
            #1 start = 1'b0; num_shots = 16'(n);
        end
        wait_done(d0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("done_count", 32'(dones - d0), 32'd1);
        check("shots_done", 32'(shots_done), reply ? 32'(n) : 32'd0);
        check("err_timeout", 32'(err_timeout), reply ? 32'd0 : 32'd1);
        check("tx_left", 32'(exp_tx.size()), 32'd0);
        check("res_left", 32'(exp_res.size()), 32'd0);
        check("rx_left", 32'(rx_q.size()), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        int d0;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              32'({tx_valid, busy, done, res_valid, shots_done, err_timeout, meas_ready, rx_ready}), 32'd0);
        check("reset_results", 32'({res_iterations, res_cycles}), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // single shot, known values
        run(1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("t1_iterations", 32'(res_iterations), 32'd2);
        check("t1_cycles", 32'(res_cycles), 32'd26);

        // single shot with toggling tx_ready
        run(1, 1'b1, 1'b1, 1, 1'b0, 1'b0);

        // three shots, random gaps, stray start while busy
        run(3, 1'b0, 1'b1, 2, 1'b1, 1'b1);

        // randomized runs
        for (int r = 0; r < 5; r++)
            run($urandom_range(4, 1), 1'b0, 1'b1, $urandom_range(2), 1'($urandom_range(1)), 1'b0);

        // reply timeout
        run(1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("timeout_latency", 32'(err_rise_cyc - last_tx_cyc), 32'(TMO + 1));

        // err_timeout cleared by the next accepted start
        run(1, 1'b1, 1'b1, 0, 1'b0, 1'b0);

        // reset while data byte 1 is being offered
        tx_mode = 0; rand_gaps = 1'b0;
        hold_base = tx_seen; hold3 = 1'b1;
        exp_tx.push_back(START_DECODING_MSG);
        push_shot(MW'(24'h00050A), 8'h11, 16'h2233, 1'b1);
        pulse_start(1);
        k = 0;
        while (!((tx_seen - hold_base) == 3 && tx_valid) && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        check("t5_reached_byte1", 32'(tx_seen - hold_base), 32'd3);
        @(posedge clk); #1 reset = 1'b1;
        meas_q.delete(); rx_q.delete(); exp_tx.delete(); exp_res.delete();
        @(posedge clk); #1 reset = 1'b0; hold3 = 1'b0;
        @(negedge clk);
        check("t5_tx_valid", 32'(tx_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        run(1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("t5_iterations", 32'(res_iterations), 32'd2);

        // zero-shot run
        d0 = dones;
        pulse_start(0);
        @(negedge clk);
        check("t6_done_pulse", 32'(done), 32'd1);
        check("t6_tx_valid", 32'(tx_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("t6_done_count", 32'(dones - d0), 32'd1);
        check("t6_tx_idle", 32'(tx_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
